// File: rtl/risc_toy_pkg.sv
// rtl/risc_toy_pkg.sv - shared widths and arbiter state encoding
// Purpose: bus widths and the arbiter FSM state enum used by mem_arbiter
//          and its interface. No ports.
package risc_toy_pkg;
    localparam int AW = 30;
    localparam int DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data/memory bus bundle for mem_arbiter
// Purpose: groups the instruction-fetch, data and shared-memory signals.
// Ports (modport slave = arbiter view, master = requester/memory view):
//   IREQ, IADDR, INSTR, IVALID, STALL_I      instruction fetch side
//   DREQ, DRW, DADDR, DWDATA, DRDATA, DVALID, STALL_D   data side
//   MREQ, MRW, MADDR, MWDATA, MRDATA, MRDY   shared memory side
//   ERR                                      sticky watchdog timeout
interface mem_arbiter_if;
    import risc_toy_pkg::*;

    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic [DW-1:0] INSTR;
    logic          IVALID;
    logic          DREQ;
    logic          DRW;
    logic [AW-1:0] DADDR;
    logic [DW-1:0] DWDATA;
    logic [DW-1:0] DRDATA;
    logic          DVALID;
    logic          MREQ;
    logic          MRW;
    logic [AW-1:0] MADDR;
    logic [DW-1:0] MWDATA;
    logic [DW-1:0] MRDATA;
    logic          MRDY;
    logic          STALL_I;
    logic          STALL_D;
    logic          ERR;

    modport slave (
        input  IREQ, IADDR, DREQ, DRW, DADDR, DWDATA, MRDATA, MRDY,
        output INSTR, IVALID, DRDATA, DVALID, MREQ, MRW, MADDR, MWDATA,
               STALL_I, STALL_D, ERR
    );

    modport master (
        output IREQ, IADDR, DREQ, DRW, DADDR, DWDATA, MRDATA, MRDY,
        input  INSTR, IVALID, DRDATA, DVALID, MREQ, MRW, MADDR, MWDATA,
               STALL_I, STALL_D, ERR
    );
endinterface

// File: rtl/mem_arb_wdog.sv
// rtl/mem_arb_wdog.sv - per-transaction watchdog for mem_arbiter
// Purpose: counts BUSY cycles without memory completion.
// Ports: clk_i, rst_i (sync active-high), clr (grant), en (busy & ~MRDY),
//        expire (combinational: this is the TMO-th counted cycle).
module mem_arb_wdog #(
    parameter int TMO = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = (TMO > 1) ? $clog2(TMO + 1) : 1;
    localparam logic [W-1:0] LIM = W'(TMO - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Fire during the TMO-th stalled cycle so the FSM leaves BUSY on the
    // same edge the count would reach TMO; MREQ is then high TMO cycles.
    assign expire = en && !clr && (cnt_q == LIM);
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data arbiter onto one shared memory port
// Purpose: grants fetch or data access to the shared memory, with data
//          priority bounded by a starvation counter and a watchdog.
// Ports: CLK, RST (sync active-high), bus (mem_arbiter_if.slave).
// Parameters: MAXD max consecutive data grants while a fetch waits,
//             TMO watchdog limit in cycles per memory transaction.
module mem_arbiter
    import risc_toy_pkg::*;
#(
    parameter int MAXD = 4,
    parameter int TMO  = 255
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);
    localparam int CW = (MAXD > 0) ? $clog2(MAXD + 1) : 1;
    localparam logic [CW-1:0] DMAX = CW'(MAXD);

    arb_state_e    state_q;
    logic [CW-1:0] dcnt_q;
    logic [DW-1:0] instr_q, drdata_q, mwdata_q;
    logic [AW-1:0] maddr_q;
    logic          ivalid_q, dvalid_q, mreq_q, mrw_q, err_q;
    logic          busy, grant_d, grant_i, expire;

    assign busy    = (state_q != IDLE);
    // Data wins unless the fetch has already been passed over MAXD times.
    assign grant_d = (state_q == IDLE) && bus.DREQ && !(bus.IREQ && dcnt_q == DMAX);
    assign grant_i = (state_q == IDLE) && !grant_d && bus.IREQ;

    mem_arb_wdog #(.TMO(TMO)) u_wdog (
        .clk_i  (CLK),
        .rst_i  (RST),
        .clr    (grant_d | grant_i),
        .en     (busy & ~bus.MRDY),
        .expire (expire)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            dcnt_q   <= '0;
            instr_q  <= '0;
            drdata_q <= '0;
            mwdata_q <= '0;
            maddr_q  <= '0;
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            mreq_q   <= 1'b0;
            mrw_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q  <= D_BUSY;
                        mreq_q   <= 1'b1;
                        maddr_q  <= bus.DADDR;
                        mrw_q    <= bus.DRW;
                        mwdata_q <= bus.DWDATA;
                        if (!bus.IREQ)
                            dcnt_q <= '0;
                        else if (dcnt_q != DMAX)
                            dcnt_q <= dcnt_q + 1'b1;
                    end else if (grant_i) begin
                        state_q <= I_BUSY;
                        mreq_q  <= 1'b1;
                        maddr_q <= bus.IADDR;
                        mrw_q   <= 1'b0;
                        dcnt_q  <= '0;
                    end
                end
                I_BUSY: begin
                    if (bus.MRDY) begin
                        instr_q  <= bus.MRDATA;
                        ivalid_q <= 1'b1;
                        mreq_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (expire) begin
                        err_q    <= 1'b1;
                        ivalid_q <= 1'b1;
                        mreq_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                D_BUSY: begin
                    if (bus.MRDY) begin
                        if (!mrw_q)
                            drdata_q <= bus.MRDATA;
                        dvalid_q <= 1'b1;
                        mreq_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (expire) begin
                        err_q    <= 1'b1;
                        dvalid_q <= 1'b1;
                        mreq_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mreq_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.INSTR   = instr_q;
    assign bus.IVALID  = ivalid_q;
    assign bus.DRDATA  = drdata_q;
    assign bus.DVALID  = dvalid_q;
    assign bus.MREQ    = mreq_q;
    assign bus.MRW     = mrw_q;
    assign bus.MADDR   = maddr_q;
    assign bus.MWDATA  = mwdata_q;
    assign bus.ERR     = err_q;
    assign bus.STALL_I = bus.IREQ & ~ivalid_q;
    assign bus.STALL_D = bus.DREQ & ~dvalid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic CLK;
    logic RST;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.MAXD(4), .TMO(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        rst, ireq;
        logic [29:0] iaddr;
        logic        dreq, drw;
        logic [29:0] daddr;
        logic [31:0] dwdata;
        logic        mrdy;
        logic [31:0] mrdata;
        logic        mreq, mrw;
        logic [29:0] maddr;
        logic [31:0] mwdata;
        logic        ivalid, dvalid;
        logic [31:0] instr, drdata;
        logic        err;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] rst, ireq, iaddr, dreq, drw, daddr, dwdata, mrdy, mrdata,
        input logic [31:0] mreq, mrw, maddr, mwdata, ivalid, dvalid, instr, drdata, err);
        vec_t r;
        r.rst = rst[0];     r.ireq = ireq[0];     r.iaddr = iaddr[29:0];
        r.dreq = dreq[0];   r.drw = drw[0];       r.daddr = daddr[29:0];
        r.dwdata = dwdata;  r.mrdy = mrdy[0];     r.mrdata = mrdata;
        r.mreq = mreq[0];   r.mrw = mrw[0];       r.maddr = maddr[29:0];
        r.mwdata = mwdata;  r.ivalid = ivalid[0]; r.dvalid = dvalid[0];
        r.instr = instr;    r.drdata = drdata;    r.err = err[0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t vt[23];

    initial begin
        RST = 1'b1;
        bus.IREQ = 0; bus.IADDR = '0; bus.DREQ = 0; bus.DRW = 0;
        bus.DADDR = '0; bus.DWDATA = '0; bus.MRDY = 0; bus.MRDATA = '0;

        //        rst ireq iaddr dreq drw daddr dwdata mrdy mrdata | mreq mrw maddr mwdata iv dv instr drdata err
        vt[0]  = mk(1,0,0,    0,0,0,    0,    0,0,            0,0,0,    0,    0,0,0,            0,            0);
        vt[1]  = mk(0,0,0,    0,0,0,    0,    1,'h1234,       0,0,0,    0,    0,0,0,            0,            0);
        vt[2]  = mk(0,1,'h10, 0,0,0,    0,    0,0,            1,0,'h10, 0,    0,0,0,            0,            0);
        vt[3]  = mk(0,1,'h10, 0,0,0,    0,    0,0,            1,0,'h10, 0,    0,0,0,            0,            0);
        vt[4]  = mk(0,1,'h10, 0,0,0,    0,    0,0,            1,0,'h10, 0,    0,0,0,            0,            0);
        vt[5]  = mk(0,1,'h10, 0,0,0,    0,    1,'hDEADBEEF,   0,0,'h10, 0,    1,0,'hDEADBEEF,   0,            0);
        vt[6]  = mk(0,0,0,    0,0,0,    0,    0,0,            0,0,'h10, 0,    0,0,'hDEADBEEF,   0,            0);
        vt[7]  = mk(0,1,'h44, 1,1,'h20, 5,    0,0,            1,1,'h20, 5,    0,0,'hDEADBEEF,   0,            0);
        vt[8]  = mk(0,1,'h44, 1,1,'h20, 5,    1,'hAAAA5555,   0,1,'h20, 5,    0,1,'hDEADBEEF,   0,            0);
        vt[9]  = mk(0,1,'h44, 0,0,0,    0,    0,0,            1,0,'h44, 5,    0,0,'hDEADBEEF,   0,            0);
        vt[10] = mk(0,1,'h44, 0,0,0,    0,    1,'h0BADF00D,   0,0,'h44, 5,    1,0,'h0BADF00D,   0,            0);
        vt[11] = mk(0,0,0,    0,0,0,    0,    0,0,            0,0,'h44, 5,    0,0,'h0BADF00D,   0,            0);
        vt[12] = mk(0,0,0,    1,0,'h30, 'h77, 0,0,            1,0,'h30, 'h77, 0,0,'h0BADF00D,   0,            0);
        vt[13] = mk(0,0,0,    1,0,'h30, 'h77, 1,'hCAFEF00D,   0,0,'h30, 'h77, 0,1,'h0BADF00D,   'hCAFEF00D,   0);
        vt[14] = mk(0,0,0,    0,0,0,    0,    0,0,            0,0,'h30, 'h77, 0,0,'h0BADF00D,   'hCAFEF00D,   0);
        vt[15] = mk(0,0,0,    1,1,'h3F, 'h99, 0,0,            1,1,'h3F, 'h99, 0,0,'h0BADF00D,   'hCAFEF00D,   0);
        vt[16] = mk(1,0,0,    1,1,'h3F, 'h99, 0,0,            0,0,0,    0,    0,0,0,            0,            0);
        vt[17] = mk(0,0,0,    0,0,0,    0,    1,'h55,         0,0,0,    0,    0,0,0,            0,            0);
        vt[18] = mk(0,0,0,    0,0,0,    0,    0,0,            0,0,0,    0,    0,0,0,            0,            0);
        vt[19] = mk(0,1,'h2,  0,0,0,    0,    0,0,            1,0,'h2,  0,    0,0,0,            0,            0);
        vt[20] = mk(0,0,0,    0,0,0,    0,    0,0,            1,0,'h2,  0,    0,0,0,            0,            0);
        vt[21] = mk(0,0,0,    0,0,0,    0,    1,'h13579BDF,   0,0,'h2,  0,    1,0,'h13579BDF,   0,            0);
        vt[22] = mk(0,0,0,    0,0,0,    0,    0,0,            0,0,'h2,  0,    0,0,'h13579BDF,   0,            0);

        for (int i = 0; i < 23; i++) begin
            @(negedge CLK);
            RST = vt[i].rst;
            bus.IREQ = vt[i].ireq;   bus.IADDR = vt[i].iaddr;
            bus.DREQ = vt[i].dreq;   bus.DRW = vt[i].drw;
            bus.DADDR = vt[i].daddr; bus.DWDATA = vt[i].dwdata;
            bus.MRDY = vt[i].mrdy;   bus.MRDATA = vt[i].mrdata;
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d MREQ", i),   32'(bus.MREQ),   32'(vt[i].mreq));
            chk($sformatf("v%0d MRW", i),    32'(bus.MRW),    32'(vt[i].mrw));
            chk($sformatf("v%0d MADDR", i),  32'(bus.MADDR),  32'(vt[i].maddr));
            chk($sformatf("v%0d MWDATA", i), bus.MWDATA,      vt[i].mwdata);
            chk($sformatf("v%0d IVALID", i), 32'(bus.IVALID), 32'(vt[i].ivalid));
            chk($sformatf("v%0d DVALID", i), 32'(bus.DVALID), 32'(vt[i].dvalid));
            chk($sformatf("v%0d INSTR", i),  bus.INSTR,       vt[i].instr);
            chk($sformatf("v%0d DRDATA", i), bus.DRDATA,      vt[i].drdata);
            chk($sformatf("v%0d ERR", i),    32'(bus.ERR),    32'(vt[i].err));
        end

        // Starvation: fetch held while data requests arrive back to back.
        @(negedge CLK);
        bus.MRDY = 0;
        bus.IREQ = 1; bus.IADDR = 30'h100;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge CLK);
            bus.MRDY = 0;
            bus.DREQ = 1; bus.DRW = 0; bus.DADDR = 30'(32'h200 + k);
            @(posedge CLK);
            #1;
            chk($sformatf("starve%0d MREQ", k), 32'(bus.MREQ), 32'd1);
            if (k < 4) begin
                chk($sformatf("starve%0d MADDR", k), 32'(bus.MADDR), 32'h200 + k);
                chk($sformatf("starve%0d dcnt", k), 32'(dut.dcnt_q), 32'(k + 1));
            end else begin
                chk("starve4 MADDR", 32'(bus.MADDR), 32'h100);
                chk("starve4 MRW", 32'(bus.MRW), 32'd0);
                chk("starve4 dcnt", 32'(dut.dcnt_q), 32'd0);
            end
            @(negedge CLK);
            bus.MRDY = 1; bus.MRDATA = 32'h100 + k;
            @(posedge CLK);
            #1;
            if (k < 4) chk($sformatf("starve%0d DVALID", k), 32'(bus.DVALID), 32'd1);
            else       chk("starve4 IVALID", 32'(bus.IVALID), 32'd1);
        end
        chk("starve INSTR", bus.INSTR, 32'h104);
        chk("starve DRDATA", bus.DRDATA, 32'h103);

        // Watchdog: data read that never completes, TMO=8.
        @(negedge CLK);
        bus.MRDY = 0; bus.IREQ = 0;
        bus.DREQ = 1; bus.DRW = 0; bus.DADDR = 30'h3;
        @(posedge CLK);
        #1;
        chk("tmo grant MREQ", 32'(bus.MREQ), 32'd1);
        chk("tmo STALL_D busy", 32'(bus.STALL_D), 32'd1);
        for (int c = 1; c < 8; c++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("tmo cyc%0d MREQ", c), 32'(bus.MREQ), 32'd1);
        end
        @(posedge CLK);
        #1;
        chk("tmo MREQ drop", 32'(bus.MREQ), 32'd0);
        chk("tmo ERR", 32'(bus.ERR), 32'd1);
        chk("tmo DVALID", 32'(bus.DVALID), 32'd1);
        chk("tmo DRDATA kept", bus.DRDATA, 32'h103);
        chk("tmo STALL_D valid", 32'(bus.STALL_D), 32'd0);
        @(negedge CLK);
        bus.DREQ = 0;
        @(posedge CLK);
        #1;
        chk("tmo DVALID once", 32'(bus.DVALID), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        chk("tmo ERR sticky", 32'(bus.ERR), 32'd1);
        @(negedge CLK);
        RST = 1;
        @(posedge CLK);
        #1;
        chk("rst clears ERR", 32'(bus.ERR), 32'd0);
        @(negedge CLK);
        RST = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
